// File: rtl/dmem_io_if.sv
// dmem_io_if: MEM-stage data bus between the pipeline and dmem_io.
//
// Bus semantics: there is no handshake. The access is accepted in the cycle it
// is presented. read_data is combinational from addr and the current state.
// A store commits on the rising clock edge where mem_write_en is high.
interface dmem_io_if;
    logic        mem_write_en;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output mem_write_en,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_write_en,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/dmem_io.sv
// dmem_io: word-addressed data RAM plus a memory-mapped I/O page at
// 0x0000FF00-0x0000FFFF for the MEM stage of the 5-stage pipeline.
//
// The I/O page provides these registers:
//   - a registered LED port
//   - a synchronized and debounced switch port
//   - sticky switch-change flags (write-1-to-clear)
//   - an optional free-running cycle counter
//
// Optional feature macro: DMEM_IO_CYCLE_COUNTER_EN.
//   - Defined: offset 0x0C is a 32-bit cycle counter. A write loads 0.
//   - Undefined: offset 0x0C reads 0 and no counter flops exist.
module dmem_io #(
    parameter int DEPTH_WORDS     = 64,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    dmem_io_if.slave   bus,
    input  logic [7:0] switches,
    output logic [7:0] leds
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW_DB  = 8'h04;
    localparam logic [7:0] OFF_SW_CHG = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h0C;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          is_io;
    logic [7:0]    io_off;
    logic [AW-1:0] ram_idx;
    logic          wr_ok;
    logic          we_ram;
    logic          we_led;
    logic          we_chg;
    logic          we_cyc;

    // Byte lanes (addr[1:0]) are ignored. Upper RAM address bits alias.
    // Both of those leave addr bits unread; this sink collects them.
    logic unused_addr;
    assign unused_addr = ^bus.addr;

    assign is_io   = (bus.addr[31:8] == 24'h0000FF);
    assign io_off  = bus.addr[7:0];
    assign ram_idx = bus.addr[AW+1:2];

    // Stores presented while reset is held are dropped everywhere,
    // including the RAM, which has no reset of its own.
    assign wr_ok  = bus.mem_write_en && !rst;
    assign we_ram = wr_ok && !is_io;
    assign we_led = wr_ok && is_io && (io_off == OFF_LED);
    assign we_chg = wr_ok && is_io && (io_off == OFF_SW_CHG);
    assign we_cyc = wr_ok && is_io && (io_off == OFF_CYCLE);

    // ------------------------------------------------------------------
    // RAM: zero at time zero, never touched by reset
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    // Store commits on the edge. A same-cycle read still sees the old word.
    always_ff @(posedge clk) begin
        if (we_ram) begin
            mem[ram_idx] <= bus.write_data;
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    // Only the low byte of a store to the LED register is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else if (we_led) begin
            leds <= bus.write_data[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Switch synchronizer, debounce and sticky change flags
    // ------------------------------------------------------------------
    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    s2_prev;
    logic [7:0]    sw_db;
    logic [7:0]    chg;
    logic [CW-1:0] cnt;
    logic          accept;
    logic [7:0]    chg_set;
    logic [7:0]    chg_clr;

    // A change is accepted once s2 has differed from sw_db and held still
    // for DEBOUNCE_CYCLES counted edges.
    assign accept  = (s2 != sw_db) && (s2 == s2_prev)
                     && (cnt == CW'(DEBOUNCE_CYCLES));
    assign chg_set = accept ? (s2 ^ sw_db) : 8'h00;
    assign chg_clr = we_chg ? bus.write_data[7:0] : 8'h00;

    // Two-flop synchronizer plus one-edge history of the synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s2_prev <= '0;
        end else begin
            s1      <= switches;
            s2      <= s1;
            s2_prev <= s2;
        end
    end

    // Debounce counter. It restarts on any movement of s2, or when there
    // is nothing new to accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            sw_db <= '0;
        end else if ((s2 == sw_db) || (s2 != s2_prev)) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            sw_db <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Sticky flags. A set on the same edge as a W1C of that bit wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg <= '0;
        end else begin
            chg <= (chg & ~chg_clr) | chg_set;
        end
    end

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_val;

`ifdef DMEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    // Free-running counter that wraps. A write loads 0 instead of
    // incrementing on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else if (we_cyc) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_val = cycle_q;
`else
    logic unused_cyc;
    assign unused_cyc = we_cyc;
    assign cycle_val  = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // Load data
    // ------------------------------------------------------------------
    // Combinational read mux. Unmapped I/O offsets return zero.
    always_comb begin
        bus.read_data = 32'h0000_0000;
        if (is_io) begin
            case (io_off)
                OFF_LED:    bus.read_data = {24'h0, leds};
                OFF_SW_DB:  bus.read_data = {24'h0, sw_db};
                OFF_SW_CHG: bus.read_data = {24'h0, chg};
                OFF_CYCLE:  bus.read_data = cycle_val;
                default:    bus.read_data = 32'h0000_0000;
            endcase
        end else begin
            bus.read_data = mem[ram_idx];
        end
    end

endmodule
